// File: rtl/sa_pkg.sv
// Shared types and defaults for the result return path (FSM states, framing constants).
// Latency: n/a. Backpressure: n/a.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEF   = 8'hA5;
  localparam int         W_RES_DEF      = 32;
  localparam int         W_DATA_DEF     = 8;
  localparam int         BYTES_PER_WORD = W_RES_DEF / W_DATA_DEF;

endpackage

// File: rtl/result_uart_serializer_word_lane_mux.sv
// Purpose: pick byte (word, lane) out of the captured result vector.
// Latency: combinational. Backpressure: none, pure select.
module word_lane_mux
  import sa_pkg::*;
#(
  parameter int COL    = 32,
  parameter int W_RES  = W_RES_DEF,
  parameter int W_DATA = W_DATA_DEF,
  parameter int WORD_W = 5,
  parameter int LANE_W = 2
) (
  input  logic [COL*W_RES-1:0] shadow,
  input  logic [WORD_W-1:0]    word,
  input  logic [LANE_W-1:0]    lane,
  output logic [W_DATA-1:0]    sel_byte
);

  logic [W_RES-1:0] word_dat;

  always_comb begin
    word_dat = shadow[word * W_RES +: W_RES];
    sel_byte = word_dat[lane * W_DATA +: W_DATA];
  end

endmodule

// File: rtl/result_uart_serializer.sv
// Purpose: capture COL result words and stream them to uart_tx as [HDR] payload [XOR CSUM].
// Latency: first o_tx_dv one cycle after i_load; each later byte one cycle after i_tx_done.
// Backpressure: holds a byte in ISSUE while i_tx_active; loads while busy are dropped (o_drop).
module result_uart_serializer
  import sa_pkg::*;
#(
  parameter int                COL        = 32,
  parameter int                W_RES      = W_RES_DEF,
  parameter int                W_DATA     = W_DATA_DEF,
  parameter logic [W_DATA-1:0] HDR_BYTE   = W_DATA'(HDR_BYTE_DEF),
  parameter int                SEND_FRAME = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_l,
  input  logic                 i_load,
  input  logic [COL*W_RES-1:0] i_results,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic                 o_tx_dv,
  output logic [W_DATA-1:0]    o_tx_byte,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_drop
);

  localparam int BPW    = W_RES / W_DATA;
  localparam int NBYTES = COL * BPW + 2 * SEND_FRAME;
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam int WORD_W = (COL > 1) ? $clog2(COL) : 1;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  state_t               state_q, state_d;
  logic [COL*W_RES-1:0] shadow_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WORD_W-1:0]    word_q;
  logic [LANE_W-1:0]    lane_q;
  logic [W_DATA-1:0]    csum_q;
  logic                 dv_q;
  logic                 drop_q;

  logic                 is_hdr, is_csum, is_last;
  logic [W_DATA-1:0]    payload_byte, cur_byte;
  logic                 issue, load_acc, advance;

  word_lane_mux #(
    .COL   (COL),
    .W_RES (W_RES),
    .W_DATA(W_DATA),
    .WORD_W(WORD_W),
    .LANE_W(LANE_W)
  ) u_mux (
    .shadow  (shadow_q),
    .word    (word_q),
    .lane    (lane_q),
    .sel_byte(payload_byte)
  );

  // Header and checksum positions are flags on idx; payload bytes come from the word/lane pair.
  always_comb begin
    is_last  = (idx_q == IDX_W'(NBYTES - 1));
    is_hdr   = (SEND_FRAME != 0) && (idx_q == '0);
    is_csum  = (SEND_FRAME != 0) && is_last;
    cur_byte = payload_byte;
    if (is_hdr)       cur_byte = HDR_BYTE;
    else if (is_csum) cur_byte = csum_q;
  end

  // dv_q is armed one cycle ahead so the strobe itself comes from a flop.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    load_acc = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          load_acc = 1'b1;
          issue    = !i_tx_active;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (dv_q)              state_d = WAIT;
        else if (!i_tx_active) issue   = 1'b1;
      end
      WAIT: begin
        if (i_tx_done) begin
          advance = 1'b1;
          if (is_last) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            issue   = !i_tx_active;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      lane_q   <= '0;
      csum_q   <= '0;
      dv_q     <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= issue;
      drop_q  <= i_load && (state_q != IDLE);
      if (load_acc) begin
        shadow_q <= i_results;
        idx_q    <= '0;
        word_q   <= '0;
        lane_q   <= '0;
        csum_q   <= '0;
      end
      if (advance) begin
        idx_q <= idx_q + 1'b1;
        if (!is_hdr && !is_csum) begin
          csum_q <= csum_q ^ payload_byte;
          if (lane_q == LANE_W'(BPW - 1)) begin
            lane_q <= '0;
            word_q <= word_q + 1'b1;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
      end
    end
  end

  assign o_tx_dv   = dv_q;
  assign o_tx_byte = (state_q == IDLE) ? '0 : cur_byte;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);
  assign o_drop    = drop_q;

endmodule

// File: tb/tb_result_uart_serializer.sv
// Scoreboard bench: two serializers (framed / payload-only) each driving a behavioural uart_tx.
module tb_result_uart_serializer;

  localparam int CPB = 4;
  localparam logic [7:0] PKT1 [10] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44,
                                       8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
  localparam logic [63:0] RES1 = {32'h88776655, 32'h44332211};

  logic        clk = 1'b0;
  logic        rst_l;
  logic [1:0]  load;
  logic [1:0]  hold;
  logic [63:0] results;
  logic [1:0]  dv, busy, done_o, drop, active;
  logic [7:0]  tx_byte [2];

  logic        active_m [2] = '{1'b0, 1'b0};
  logic        done_m   [2] = '{1'b0, 1'b0};
  int          cnt      [2] = '{0, 0};
  logic [7:0]  held     [2] = '{8'h00, 8'h00};

  logic [7:0]  exp_q0 [$];
  logic [7:0]  exp_q1 [$];
  int          sent     [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  logic        prev_dv  [2] = '{1'b0, 1'b0};
  logic        prev_dm  [2] = '{1'b0, 1'b0};
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign active = {active_m[1] | hold[1], active_m[0] | hold[0]};

  result_uart_serializer #(.COL(2), .SEND_FRAME(1)) dut_frm (
    .i_clk(clk), .i_rst_l(rst_l), .i_load(load[0]), .i_results(results),
    .i_tx_active(active[0]), .i_tx_done(done_m[0]), .o_tx_dv(dv[0]),
    .o_tx_byte(tx_byte[0]), .o_busy(busy[0]), .o_done(done_o[0]), .o_drop(drop[0]));

  result_uart_serializer #(.COL(2), .SEND_FRAME(0)) dut_raw (
    .i_clk(clk), .i_rst_l(rst_l), .i_load(load[1]), .i_results(results),
    .i_tx_active(active[1]), .i_tx_done(done_m[1]), .o_tx_dv(dv[1]),
    .o_tx_byte(tx_byte[1]), .o_busy(busy[1]), .o_done(done_o[1]), .o_drop(drop[1]));

  // Behavioural uart_tx: 10-bit frame of CPB clocks per bit, done and active change together.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      done_m[c] <= 1'b0;
      if (!active_m[c]) begin
        if (dv[c]) begin
          active_m[c] <= 1'b1;
          cnt[c]      <= 0;
          held[c]     <= tx_byte[c];
        end
      end else if (cnt[c] == 10 * CPB - 1) begin
        active_m[c] <= 1'b0;
        done_m[c]   <= 1'b1;
      end else begin
        cnt[c] <= cnt[c] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and checks done/stability framing.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (dv[c]) begin
        check($sformatf("ch%0d_dv_spacing", c), 32'(prev_dv[c]), 32'd0);
        check($sformatf("ch%0d_dv_while_active", c), 32'(active[c]), 32'd0);
        sent[c]++;
        if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
          check($sformatf("ch%0d_unexpected_byte", c), 32'(tx_byte[c]), 32'hFFFF_FFFF);
        end else if (c == 0) begin
          check("ch0_byte", 32'(tx_byte[0]), 32'(exp_q0.pop_front()));
        end else begin
          check("ch1_byte", 32'(tx_byte[1]), 32'(exp_q1.pop_front()));
        end
      end
      if (done_m[c] && busy[c])
        check($sformatf("ch%0d_byte_stable", c), 32'(tx_byte[c]), 32'(held[c]));
      if (done_o[c]) begin
        done_cnt[c]++;
        check($sformatf("ch%0d_done_timing", c), 32'(prev_dm[c]), 32'd1);
        check($sformatf("ch%0d_done_all_bytes", c),
              (c == 0) ? 32'(exp_q0.size()) : 32'(exp_q1.size()), 32'd0);
      end
      prev_dv[c] = dv[c];
      prev_dm[c] = done_m[c];
    end
  end

  task automatic push_pkt1();
    for (int i = 0; i < 10; i++) exp_q0.push_back(PKT1[i]);
  endtask

  task automatic do_load(input int c, input logic [63:0] r);
    @(negedge clk);
    results = r;
    load[c] = 1'b1;
    @(negedge clk);
    load[c] = 1'b0;
  endtask

  task automatic wait_done(input int c, input int target);
    int k;
    k = 0;
    while (done_cnt[c] < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("ch%0d_done_timeout", c), 32'(done_cnt[c] >= target), 32'd1);
  endtask

  task automatic wait_sent(input int c, input int target);
    int k;
    k = 0;
    while (sent[c] < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("ch%0d_sent_timeout", c), 32'(sent[c] >= target), 32'd1);
  endtask

  initial begin
    int base;
    int k;
    rst_l   = 1'b0;
    load    = 2'b00;
    hold    = 2'b00;
    results = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_dv",    32'(dv),      32'd0);
    check("rst_done",  32'(done_o),  32'd0);
    check("rst_drop",  32'(drop),    32'd0);
    check("rst_byte0", 32'(tx_byte[0]), 32'd0);
    check("rst_byte1", 32'(tx_byte[1]), 32'd0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // Basic framed packet and first-byte latency
    push_pkt1();
    do_load(0, RES1);
    check("lat_dv",   32'(dv[0]),      32'd1);
    check("lat_byte", 32'(tx_byte[0]), 32'hA5);
    check("lat_busy", 32'(busy[0]),    32'd1);
    wait_done(0, 1);
    repeat (3) @(negedge clk);
    check("pkt1_done_once", 32'(done_cnt[0]), 32'd1);
    check("pkt1_idle",      32'(busy[0]),     32'd0);

    // uart busy at load: no strobe until it goes idle
    hold[0] = 1'b1;
    push_pkt1();
    do_load(0, RES1);
    for (int i = 0; i < 20; i++) begin
      check("hold_no_dv", 32'(dv[0]), 32'd0);
      @(negedge clk);
    end
    hold[0] = 1'b0;
    @(negedge clk);
    check("hold_release_dv",   32'(dv[0]),      32'd1);
    check("hold_release_byte", 32'(tx_byte[0]), 32'hA5);
    wait_done(0, 2);

    // Load while busy is dropped and does not disturb the packet
    push_pkt1();
    do_load(0, RES1);
    wait_sent(0, 23);
    do_load(0, {32'hDEADBEEF, 32'hCAFEF00D});
    check("drop_pulse", 32'(drop[0]), 32'd1);
    @(negedge clk);
    check("drop_single", 32'(drop[0]), 32'd0);
    wait_done(0, 3);

    // Mid-packet reset, then a clean packet
    push_pkt1();
    base = sent[0];
    do_load(0, RES1);
    wait_sent(0, base + 5);
    repeat (3) @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_dv",   32'(dv[0]),   32'd0);
    exp_q0.delete();
    k = 0;
    while (active[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("midrst_uart_idle", 32'(active[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt[0]), 32'd3);
    push_pkt1();
    do_load(0, RES1);
    wait_done(0, 4);

    // Payload-only instance
    for (int i = 0; i < 8; i++) exp_q1.push_back(8'hFF);
    do_load(1, {64{1'b1}});
    check("raw_first_byte", 32'(tx_byte[1]), 32'hFF);
    wait_done(1, 1);
    repeat (3) @(negedge clk);
    check("raw_sent",  32'(sent[1]),     32'd8);
    check("raw_done",  32'(done_cnt[1]), 32'd1);
    check("q0_empty",  32'(exp_q0.size()), 32'd0);
    check("q1_empty",  32'(exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
